// File: rtl/lut_page_loader_pkg.sv
// Shared constants and FSM encoding for the LUT page loader.
// Width defaults here match the default parameterisation of lut_page_loader.
package lut_page_loader_pkg;

    localparam int DEF_QUAN_SIZE       = 3;
    localparam int DEF_PAGE_NUM        = 16;
    localparam int DEF_BANK_INTERLEAVE = 2;
    localparam int DEF_ADDR_BITWIDTH   = 4;

    localparam int PAGE_SIZE  = DEF_QUAN_SIZE * DEF_BANK_INTERLEAVE;
    localparam int WORD_IDX_W = $clog2(DEF_BANK_INTERLEAVE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } loader_state_e;

endpackage

// File: rtl/lut_word_packer.sv
// Shift-style page pack register with word counter; flags the word that completes a page.
// The first word of a page ends up in the most significant slot.
module lut_word_packer
    import lut_page_loader_pkg::*;
#(
    parameter int QUAN_SIZE       = DEF_QUAN_SIZE,
    parameter int BANK_INTERLEAVE = DEF_BANK_INTERLEAVE
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   clear,
    input  logic                                   accept,
    input  logic [QUAN_SIZE-1:0]                   word,
    output logic                                   page_full,
    output logic [QUAN_SIZE*BANK_INTERLEAVE-1:0]   next_page
);

    localparam int PAGE_W = QUAN_SIZE * BANK_INTERLEAVE;
    localparam int CNT_W  = $clog2(BANK_INTERLEAVE);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BANK_INTERLEAVE - 1);

    logic [PAGE_W-1:0] pack_r;
    logic [CNT_W-1:0]  cnt_r;

    assign next_page = {pack_r[PAGE_W-QUAN_SIZE-1:0], word};
    assign page_full = accept && (cnt_r == LAST_IDX);

    // pack register and word index, cleared whenever no sweep is filling
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pack_r <= {PAGE_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            pack_r <= {PAGE_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
        end else if (accept) begin
            pack_r <= next_page;
            cnt_r  <= page_full ? {CNT_W{1'b0}} : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            pack_r <= pack_r;
            cnt_r  <= cnt_r;
        end
    end

endmodule

// File: rtl/lut_page_loader.sv
// Write-side feeder for the 2-bank LUT memory: packs streamed words into pages
// and sweeps page addresses 0..PAGE_NUM-1 once per load request.
module lut_page_loader
    import lut_page_loader_pkg::*;
#(
    parameter int QUAN_SIZE       = DEF_QUAN_SIZE,
    parameter int PAGE_NUM        = DEF_PAGE_NUM,
    parameter int BANK_INTERLEAVE = DEF_BANK_INTERLEAVE,
    parameter int ADDR_BITWIDTH   = DEF_ADDR_BITWIDTH
) (
    input  logic                                 write_clk,
    input  logic                                 rstn,
    input  logic                                 load_start_i,
    input  logic                                 abort_i,
    input  logic [QUAN_SIZE-1:0]                 word_i,
    input  logic                                 word_valid_i,
    output logic                                 word_ready_o,
    output logic [QUAN_SIZE*BANK_INTERLEAVE-1:0] write_data_o,
    output logic [ADDR_BITWIDTH-1:0]             write_addr_o,
    output logic                                 we_o,
    output logic                                 busy_o,
    output logic                                 done_o
);

    localparam int PAGE_W = QUAN_SIZE * BANK_INTERLEAVE;
    localparam logic [ADDR_BITWIDTH-1:0] LAST_PAGE = ADDR_BITWIDTH'(PAGE_NUM - 1);

    loader_state_e             state_r;
    logic [ADDR_BITWIDTH-1:0]  page_cnt_r;
    logic                      accept_s;
    logic                      pack_accept_s;
    logic                      pack_clear_s;
    logic                      page_full_s;
    logic [PAGE_W-1:0]         next_page_s;

    assign word_ready_o  = (state_r == ST_FILL);
    assign accept_s      = word_valid_i && word_ready_o;
    // a word arriving together with abort is dropped, not packed
    assign pack_accept_s = accept_s && !abort_i;
    assign pack_clear_s  = (state_r != ST_FILL) || abort_i;

    lut_word_packer #(
        .QUAN_SIZE      (QUAN_SIZE),
        .BANK_INTERLEAVE(BANK_INTERLEAVE)
    ) u_packer (
        .clk      (write_clk),
        .rstn     (rstn),
        .clear    (pack_clear_s),
        .accept   (pack_accept_s),
        .word     (word_i),
        .page_full(page_full_s),
        .next_page(next_page_s)
    );

    // sweep FSM, page counter and registered memory write port
    always_ff @(posedge write_clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            page_cnt_r   <= {ADDR_BITWIDTH{1'b0}};
            write_data_o <= {PAGE_W{1'b0}};
            write_addr_o <= {ADDR_BITWIDTH{1'b0}};
            we_o         <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            we_o   <= 1'b0;
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_start_i && !abort_i) begin
                        state_r    <= ST_FILL;
                        page_cnt_r <= {ADDR_BITWIDTH{1'b0}};
                        busy_o     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (abort_i) begin
                        state_r <= ST_IDLE;
                        busy_o  <= 1'b0;
                    end else if (page_full_s) begin
                        we_o         <= 1'b1;
                        write_data_o <= next_page_s;
                        write_addr_o <= page_cnt_r;
                        page_cnt_r   <= page_cnt_r + {{(ADDR_BITWIDTH-1){1'b0}}, 1'b1};
                        state_r      <= (page_cnt_r == LAST_PAGE) ? ST_DONE : ST_FILL;
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_page_loader.sv
// Directed testbench for lut_page_loader with hand-computed expectations.
module tb_lut_page_loader;

    logic       write_clk;
    logic       rstn;
    logic       load_start_i;
    logic       abort_i;
    logic [2:0] word_i;
    logic       word_valid_i;
    logic       word_ready_o;
    logic [5:0] write_data_o;
    logic [3:0] write_addr_o;
    logic       we_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;

    lut_page_loader dut (
        .write_clk   (write_clk),
        .rstn        (rstn),
        .load_start_i(load_start_i),
        .abort_i     (abort_i),
        .word_i      (word_i),
        .word_valid_i(word_valid_i),
        .word_ready_o(word_ready_o),
        .write_data_o(write_data_o),
        .write_addr_o(write_addr_o),
        .we_o        (we_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    task automatic step();
        @(posedge write_clk);
        #1;
    endtask

    task automatic start_sweep();
        load_start_i = 1'b1;
        step();
        load_start_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || word_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL start: busy=%b ready=%b, required 1 1", busy_o, word_ready_o);
        end
    endtask

    task automatic send_word(input logic [2:0] w);
        word_valid_i = 1'b1;
        word_i = w;
        step();
        word_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        #12;
        checks++;
        if ({word_ready_o, we_o, busy_o, done_o, write_data_o, write_addr_o} !== 14'd0) begin
            errors++;
            $display("FAIL reset_init: rdy=%b we=%b busy=%b done=%b data=%b addr=%0d, required all 0",
                     word_ready_o, we_o, busy_o, done_o, write_data_o, write_addr_o);
        end
        rstn = 1'b1;
        step();
        start_sweep();
        send_word(3'd5);
        send_word(3'd6);
        checks++;
        if (we_o !== 1'b1 || write_data_o !== 6'b101_110 || write_addr_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_prewrite: we=%b data=%b addr=%0d, required 1 101110 0",
                     we_o, write_data_o, write_addr_o);
        end
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if ({word_ready_o, we_o, busy_o, done_o, write_data_o, write_addr_o} !== 14'd0) begin
            errors++;
            $display("FAIL reset_async: rdy=%b we=%b busy=%b done=%b data=%b addr=%0d, required all 0",
                     word_ready_o, we_o, busy_o, done_o, write_data_o, write_addr_o);
        end
        rstn = 1'b1;
        step();
        checks++;
        if (word_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: ready=%b busy=%b, required 0 0", word_ready_o, busy_o);
        end
    endtask

    task automatic test_stream(input int gap, input int spacing);
        int idx = 0;
        int nw = 0;
        int nd = 0;
        int prev_wc = 0;
        int cyc;
        logic [2:0] a;
        logic [2:0] b;
        logic [5:0] exp_data;
        start_sweep();
        for (cyc = 0; cyc < 200 && nd == 0; cyc++) begin
            if (idx < 32 && (gap == 0 || cyc % 2 == 0)) begin
                word_valid_i = 1'b1;
                word_i = 3'(idx);
                idx++;
            end else begin
                word_valid_i = 1'b0;
            end
            step();
            if (we_o === 1'b1) begin
                a = 3'(2 * nw);
                b = 3'(2 * nw + 1);
                exp_data = {a, b};
                checks++;
                if (write_addr_o !== 4'(nw) || write_data_o !== exp_data) begin
                    errors++;
                    $display("FAIL stream_page: gap=%0d addr=%0d data=%b, required %0d %b",
                             gap, write_addr_o, write_data_o, nw, exp_data);
                end
                if (nw > 0) begin
                    checks++;
                    if (cyc - prev_wc !== spacing) begin
                        errors++;
                        $display("FAIL stream_spacing: gap=%0d spacing=%0d, required %0d",
                                 gap, cyc - prev_wc, spacing);
                    end
                end
                if (nw == 0) begin
                    checks++;
                    if (write_data_o !== 6'b000_001) begin
                        errors++;
                        $display("FAIL stream_addr0: data=%b, required 000001", write_data_o);
                    end
                end
                if (nw == 15) begin
                    checks++;
                    if (write_data_o !== 6'b110_111 || word_ready_o !== 1'b0) begin
                        errors++;
                        $display("FAIL stream_addr15: data=%b ready=%b, required 110111 0",
                                 write_data_o, word_ready_o);
                    end
                end
                prev_wc = cyc;
                nw++;
            end
            if (done_o === 1'b1) begin
                nd++;
                checks++;
                if (cyc !== prev_wc + 1 || busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_done_time: gap=%0d cyc=%0d busy=%b, required %0d 0",
                             gap, cyc, busy_o, prev_wc + 1);
                end
            end
        end
        word_valid_i = 1'b0;
        checks++;
        if (nw !== 16 || nd !== 1) begin
            errors++;
            $display("FAIL stream_counts: gap=%0d writes=%0d dones=%0d, required 16 1", gap, nw, nd);
        end
        step();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || word_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL stream_after: done=%b busy=%b ready=%b, required 0 0 0",
                     done_o, busy_o, word_ready_o);
        end
    endtask

    task automatic test_abort();
        int nw = 0;
        logic [5:0] exp_tab [2];
        exp_tab[0] = 6'b001_010;
        exp_tab[1] = 6'b011_100;
        start_sweep();
        for (int i = 0; i < 5; i++) begin
            send_word(3'(i + 1));
            if (we_o === 1'b1) begin
                checks++;
                if (nw > 1 || write_addr_o !== 4'(nw) || write_data_o !== exp_tab[nw[0]]) begin
                    errors++;
                    $display("FAIL abort_page: n=%0d addr=%0d data=%b", nw, write_addr_o, write_data_o);
                end
                nw++;
            end
        end
        abort_i = 1'b1;
        word_valid_i = 1'b1;
        word_i = 3'd6;
        step();
        abort_i = 1'b0;
        word_valid_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || word_ready_o !== 1'b0 || we_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b ready=%b we=%b, required 0 0 0", busy_o, word_ready_o, we_o);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            if (we_o === 1'b1) nw++;
            checks++;
            if (done_o !== 1'b0) begin
                errors++;
                $display("FAIL abort_done: done=%b, required 0", done_o);
            end
        end
        checks++;
        if (nw !== 2) begin
            errors++;
            $display("FAIL abort_writes: writes=%0d, required 2", nw);
        end
        start_sweep();
        send_word(3'd7);
        send_word(3'd0);
        checks++;
        if (we_o !== 1'b1 || write_addr_o !== 4'd0 || write_data_o !== 6'b111_000) begin
            errors++;
            $display("FAIL abort_restart: we=%b addr=%0d data=%b, required 1 0 111000",
                     we_o, write_addr_o, write_data_o);
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
    endtask

    task automatic test_start_controls();
        load_start_i = 1'b1;
        abort_i = 1'b1;
        step();
        load_start_i = 1'b0;
        abort_i = 1'b0;
        checks++;
        if (word_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_abort_same: ready=%b busy=%b, required 0 0", word_ready_o, busy_o);
        end
        start_sweep();
        send_word(3'd2);
        send_word(3'd3);
        checks++;
        if (we_o !== 1'b1 || write_addr_o !== 4'd0 || write_data_o !== 6'b010_011) begin
            errors++;
            $display("FAIL fill_page0: we=%b addr=%0d data=%b, required 1 0 010011",
                     we_o, write_addr_o, write_data_o);
        end
        load_start_i = 1'b1;
        send_word(3'd4);
        load_start_i = 1'b0;
        send_word(3'd5);
        checks++;
        if (we_o !== 1'b1 || write_addr_o !== 4'd1 || write_data_o !== 6'b100_101) begin
            errors++;
            $display("FAIL fill_restart_ignored: we=%b addr=%0d data=%b, required 1 1 100101",
                     we_o, write_addr_o, write_data_o);
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
    endtask

    task automatic test_idle_valid();
        word_valid_i = 1'b1;
        word_i = 3'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (we_o !== 1'b0 || word_ready_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid: we=%b ready=%b busy=%b, required 0 0 0",
                         we_o, word_ready_o, busy_o);
            end
        end
        word_valid_i = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        load_start_i = 1'b0;
        abort_i = 1'b0;
        word_i = 3'd0;
        word_valid_i = 1'b0;
        test_reset();
        test_stream(0, 2);
        test_stream(1, 4);
        test_abort();
        test_start_controls();
        test_idle_valid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lut_page_loader.md
Name: lut_page_loader

Overview:
- Write-side feeder for the 2-bank simple-dual-port LUT memory.
- Accepts a serial stream of QUAN_SIZE-bit LUT words over a valid/ready handshake and packs BANK_INTERLEAVE consecutive words into one page.
- Drives the memory write port (data, address, write enable) and sweeps pages 0..PAGE_NUM-1 once per load request.
- Sits between the LUT configuration source and the memory's write_clk domain.

Parameters:
- QUAN_SIZE, 3, bits per LUT word.
- PAGE_NUM, 16, pages per load sweep; must be ≤ 2**ADDR_BITWIDTH.
- BANK_INTERLEAVE, 2, words per page; must be ≥ 2.
- ADDR_BITWIDTH, 4, page address width.

Ports:
- write_clk  in  1  single clock; all logic is posedge write_clk.
- rstn  in  1  asynchronous, active-low reset.
- load_start_i  in  1  one-cycle request to start a full sweep.
- abort_i  in  1  synchronous abort of the current sweep.
- word_i  in  QUAN_SIZE  incoming LUT word.
- word_valid_i  in  1  word_i is valid.
- word_ready_o  out  1  loader accepts word_i this cycle.
- write_data_o  out  QUAN_SIZE*BANK_INTERLEAVE  page to the memory write_data_i.
- write_addr_o  out  ADDR_BITWIDTH  page address to the memory write_addr_i.
- we_o  out  1  write enable to the memory we_i.
- busy_o  out  1  sweep in progress.
- done_o  out  1  one-cycle pulse when a sweep completes.

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE; word_ready_o=0, we_o=0, busy_o=0, done_o=0; write_data_o, write_addr_o, word counter and page counter are all 0.
- FSM has three states: IDLE, FILL, DONE.
- IDLE
  - load_start_i=1 and abort_i=0 -> FILL; page counter and word counter cleared; busy_o=1 from the next cycle.
- FILL
  - word_ready_o=1 combinationally.
  - A word is accepted on a cycle where word_valid_i & word_ready_o.
  - Word index j (0..BANK_INTERLEAVE-1) within the page goes into pack-register bits [(BANK_INTERLEAVE-j)*QUAN_SIZE-1 : (BANK_INTERLEAVE-1-j)*QUAN_SIZE]. The first word lands in the MSB slot, matching the memory's strobe=0 upper-word read.
- Page write
  - On accepting word j=BANK_INTERLEAVE-1, the cycle after acceptance has we_o=1 for exactly one cycle.
  - In that cycle, write_data_o carries the full page and write_addr_o = page counter.
  - The page counter increments after the write. The word counter wraps to 0.
  - Write latency: 1 cycle after the last word of the page.
- Back-to-back streaming: ready stays high during the write cycle, so an unbroken valid stream gives one page write every BANK_INTERLEAVE cycles with no bubbles.
- Sweep end: acceptance of the final word of page PAGE_NUM-1 -> DONE.
  - word_ready_o drops in the same cycle the state becomes DONE.
  - The final write (we_o=1, addr=PAGE_NUM-1) occurs in the DONE cycle.
- DONE: done_o=1 for one cycle, busy_o=0 -> IDLE.
- write_data_o and write_addr_o hold their last values when we_o=0.
- load_start_i while in FILL or DONE is ignored.
- abort_i in FILL: next state is IDLE and the partial page is discarded. A word accepted in the abort cycle is dropped. A write already scheduled for that cycle still completes. No done_o.
- abort_i and load_start_i in the same IDLE cycle: abort wins and the loader stays IDLE.
- word_valid_i outside FILL: ignored, no acceptance.
- Reset mid-sweep: immediate return to reset values. A partially written memory is the system's responsibility.

Decomposition:
- Shared package holds:
  - PAGE_SIZE = QUAN_SIZE*BANK_INTERLEAVE
  - WORD_IDX_W = clog2(BANK_INTERLEAVE)
  - FSM state encoding (IDLE=2'd0, FILL=2'd1, DONE=2'd2)
- Sub-module: lut_word_packer, a shift-style pack register plus word counter that asserts page_full.
- The FSM and page counter stay in the top level.

Test Plan:
- Reset with rstn=0 mid-FILL -> all outputs 0 immediately (asynchronous); state IDLE after release.
- load_start_i, then 32 words 3'd0..3'd7 repeating with continuous valid -> 16 writes, page k data = {word 2k, word 2k+1}.
  - Check addr 0 data=6'b000_001 and addr 15 data=6'b110_111.
  - we_o asserted every 2nd cycle; done_o pulses once, in the cycle after the final write.
- Same stream with word_valid_i toggling 1,0,1,0 -> identical page contents and addresses; write spacing 4 cycles.
- abort_i after 5 words accepted -> 2 writes (addr 0,1); 5th word dropped; no done_o; busy_o=0; a new load_start_i restarts at addr 0.
- load_start_i with abort_i in the same IDLE cycle -> stays IDLE, word_ready_o=0. load_start_i pulsed during FILL -> no restart; page counter continues.
- word_valid_i=1 while IDLE with word_i=3'd5 -> no acceptance, we_o stays 0.
